// File: rtl/ramp_pkg.sv
// ---------------------------------------------------------------------------
// ramp_pkg
// Shared definitions for the ramp sequencer: step-code values, the
// step-size lookup, the default ramp limits and the sequencer state type.
// ---------------------------------------------------------------------------
package ramp_pkg;

    localparam int unsigned RAMP_CNT_W   = 12;
    localparam int unsigned RAMP_DIV_W   = 16;
    localparam int unsigned RAMP_MAX_VAL = 4095;

    // Step codes understood by the ramp datapath
    localparam logic [1:0] Y_ZERO    = 2'b00;
    localparam logic [1:0] Y_ONE     = 2'b01;
    localparam logic [1:0] Y_SIXTEEN = 2'b10;
    localparam logic [1:0] Y_BIG     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WRAP,
        DONE
    } state_t;

    // Increment the ramp applies on one delta strobe for a given step code
    function automatic logic [RAMP_CNT_W-1:0] step_of(input logic [1:0] code);
        logic [RAMP_CNT_W-1:0] step;
        case (code)
            Y_ZERO:    step = 12'd0;
            Y_ONE:     step = 12'd1;
            Y_SIXTEEN: step = 12'd16;
            Y_BIG:     step = 12'd1290;
            default:   step = 12'd0;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// ---------------------------------------------------------------------------
// ramp_prescaler
// Rate divider for the ramp sequencer. The counter holds the position of
// the *upcoming* RUN cycle inside the div+1 period, so tick is known one
// cycle ahead and the sequencer can register delta for the tick cycle.
// Ports:
//   clk   in  1      clock
//   rst   in  1      asynchronous active-high reset
//   run   in  1      next cycle is a RUN cycle (0 clears the count)
//   div   in  DIV_W  period minus 1
//   tick  out 1      upcoming RUN cycle is a tick cycle
// ---------------------------------------------------------------------------
module ramp_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = (cnt_reg == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!run || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ramp_sequencer.sv
// ---------------------------------------------------------------------------
// ramp_sequencer
// Drives the pattern ramp: enable, one-cycle step strobe and step code,
// generated at a programmable rate from a configuration latched on start.
// A shadow of the ramp level decides when the next step would exceed
// MAX_VAL; the run then ends (single-shot) or restarts from 0 (continuous).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, stop      run request / abort (stop has priority)
//   y_sel, div, cont configuration, latched on an accepted start
//   ramp_enb         ramp enable (0 clears the ramp)
//   delta, y         step strobe and latched step code
//   level            ramp level including the step strobed this cycle
//   busy             high in ARM, RUN, WRAP
//   done, wrap       one-cycle completion / restart pulses
// All outputs are registered.
// ---------------------------------------------------------------------------
module ramp_sequencer
    import ramp_pkg::*;
#(
    parameter int unsigned CNT_W   = RAMP_CNT_W,
    parameter int unsigned MAX_VAL = RAMP_MAX_VAL,
    parameter int unsigned DIV_W   = RAMP_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       y_sel,
    input  logic [DIV_W-1:0] div,
    input  logic             cont,
    output logic             ramp_enb,
    output logic             delta,
    output logic [1:0]       y,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state_reg;
    logic [1:0]       y_reg;
    logic [DIV_W-1:0] div_reg;
    logic             cont_reg;
    logic [CNT_W-1:0] level_reg;
    logic             ramp_enb_reg;
    logic             delta_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             wrap_reg;

    logic             tick;
    logic             run_next;
    logic             ovf;
    logic [CNT_W:0]   sum;

    // The prescaler must know whether the next cycle is a RUN cycle so its
    // look-ahead count is only consumed by real RUN cycles.
    always_comb begin
        sum      = {1'b0, level_reg} + (CNT_W+1)'(step_of(y_reg));
        ovf      = (sum > (CNT_W+1)'(MAX_VAL));
        run_next = 1'b0;
        if (!stop) begin
            case (state_reg)
                ARM, RUN, WRAP: run_next = !(tick && ovf);
                default:        run_next = 1'b0;
            endcase
        end
    end

    ramp_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run_next),
        .div  (div_reg),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            y_reg        <= '0;
            div_reg      <= '0;
            cont_reg     <= 1'b0;
            level_reg    <= '0;
            ramp_enb_reg <= 1'b0;
            delta_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            delta_reg <= 1'b0;
            done_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            if (stop) begin
                state_reg    <= IDLE;
                ramp_enb_reg <= 1'b0;
                level_reg    <= '0;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start) begin
                            y_reg        <= y_sel;
                            div_reg      <= div;
                            cont_reg     <= cont;
                            state_reg    <= ARM;
                            ramp_enb_reg <= 1'b0;
                            level_reg    <= '0;
                            busy_reg     <= 1'b1;
                        end
                    end
                    ARM, RUN, WRAP: begin
                        // Decisions here describe the next cycle, which is
                        // the tick cycle when tick is high.
                        if (tick && ovf) begin
                            if (cont_reg) begin
                                state_reg    <= WRAP;
                                wrap_reg     <= 1'b1;
                                ramp_enb_reg <= 1'b0;
                                level_reg    <= '0;
                                busy_reg     <= 1'b1;
                            end else begin
                                state_reg    <= DONE;
                                done_reg     <= 1'b1;
                                ramp_enb_reg <= 1'b1;
                                busy_reg     <= 1'b0;
                            end
                        end else begin
                            state_reg    <= RUN;
                            ramp_enb_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            if (tick) begin
                                delta_reg <= 1'b1;
                                level_reg <= sum[CNT_W-1:0];
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign ramp_enb = ramp_enb_reg;
    assign delta    = delta_reg;
    assign y        = y_reg;
    assign level    = level_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign wrap     = wrap_reg;

endmodule

// File: tb/tb_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ramp_sequencer
// Self-checking bench: every cycle the DUT outputs are compared against a
// behavioural model that counts RUN cycles since the run (re)started and
// derives ticks with modulo arithmetic. Directed scenarios plus random
// start/stop/config traffic; one line printed per scenario.
// ---------------------------------------------------------------------------
module tb_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  y_sel;
    logic [15:0] div;
    logic        cont;
    logic        ramp_enb;
    logic        delta;
    logic [1:0]  y;
    logic [11:0] level;
    logic        busy;
    logic        done;
    logic        wrap;

    always #5 clk = ~clk;

    ramp_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .y_sel    (y_sel),
        .div      (div),
        .cont     (cont),
        .ramp_enb (ramp_enb),
        .delta    (delta),
        .y        (y),
        .level    (level),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_ARM, M_RUN, M_RESTART, M_END} mode_t;
    mode_t m_mode;
    int    m_run_cycles;
    int    m_level;
    int    m_y;
    int    m_div;
    bit    m_cont;
    bit    e_enb, e_delta, e_done, e_wrap, e_busy;
    int    steps [4] = '{0, 1, 16, 1290};

    // per-scenario statistics
    int n_delta, n_done, n_wrap, max_level;

    task automatic model_reset();
        m_mode = M_OFF; m_run_cycles = 0; m_level = 0;
        m_y = 0; m_div = 0; m_cont = 0;
        e_enb = 0; e_delta = 0; e_done = 0; e_wrap = 0; e_busy = 0;
    endtask

    // Expected outputs for the cycle following an edge that sampled these inputs
    task automatic model_step(input bit st, input bit sp, input int ys, input int dv, input bit ct);
        int n;
        bit tk;
        e_delta = 0; e_done = 0; e_wrap = 0;
        if (sp) begin
            m_mode = M_OFF; e_enb = 0; m_level = 0; e_busy = 0;
        end else if (m_mode == M_OFF || m_mode == M_END) begin
            if (st) begin
                m_y = ys; m_div = dv; m_cont = ct;
                m_mode = M_ARM; e_enb = 0; m_level = 0; e_busy = 1;
            end
        end else begin
            n  = (m_mode == M_RUN) ? m_run_cycles + 1 : 1;
            tk = ((n % (m_div + 1)) == 0);
            if (tk && (m_level + steps[m_y] > 4095)) begin
                if (m_cont) begin
                    m_mode = M_RESTART; e_wrap = 1; e_enb = 0; m_level = 0; e_busy = 1;
                end else begin
                    m_mode = M_END; e_done = 1; e_enb = 1; e_busy = 0;
                end
            end else begin
                m_mode = M_RUN; m_run_cycles = n; e_enb = 1; e_busy = 1;
                if (tk) begin
                    e_delta = 1;
                    m_level = m_level + steps[m_y];
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("ramp_enb", ramp_enb, e_enb);
        check_val("delta",    delta,    e_delta);
        check_val("y",        y,        m_y);
        check_val("level",    level,    m_level);
        check_val("busy",     busy,     e_busy);
        check_val("done",     done,     e_done);
        check_val("wrap",     wrap,     e_wrap);
    endtask

    task automatic clear_stats();
        n_delta = 0; n_done = 0; n_wrap = 0; max_level = 0;
    endtask

    // One clock: drive inputs, let the edge sample them, then check
    task automatic cyc(input bit st, input bit sp, input logic [1:0] ys,
                       input logic [15:0] dv, input bit ct);
        start = st; stop = sp; y_sel = ys; div = dv; cont = ct;
        @(posedge clk);
        model_step(st, sp, int'(ys), int'(dv), ct);
        #1;
        compare_all();
        n_delta += int'(delta);
        n_done  += int'(done);
        n_wrap  += int'(wrap);
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    // Idle-handed cycle with random configuration inputs (must be ignored)
    task automatic cyc_noise(input bit st, input bit sp);
        cyc(st, sp, 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; y_sel = 0; div = 0; cont = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
        $display("scenario reset: checks %0d", checks);

        // Single-shot with the big step: three steps then completion
        clear_stats();
        cyc(1, 0, 2'b11, 16'd0, 1'b0);
        repeat (7) cyc_noise(0, 0);
        check_val("big_deltas", n_delta, 3);
        check_val("big_done",   n_done, 1);
        check_val("big_final",  level, 3870);
        $display("scenario single_shot_big: deltas %0d done %0d", n_delta, n_done);

        // Restart from DONE with unit steps
        clear_stats();
        cyc(1, 0, 2'b01, 16'd0, 1'b0);
        check_val("rearm_enb", ramp_enb, 0);
        cyc_noise(0, 0);
        check_val("restart_level", level, 1);
        repeat (5) cyc_noise(0, 0);
        $display("scenario restart_from_done: level %0d", level);

        // Continuous, step 16, every 4th RUN cycle: one wrap at 4080
        cyc_noise(0, 1);
        clear_stats();
        cyc(1, 0, 2'b10, 16'd3, 1'b1);
        repeat (1100) cyc_noise(0, 0);
        check_val("cont_wraps", n_wrap, 1);
        check_val("cont_max",   max_level, 4080);
        check_val("cont_done",  n_done, 0);
        $display("scenario continuous_wrap: deltas %0d wraps %0d max %0d", n_delta, n_wrap, max_level);

        // Stop together with start mid-run
        cyc_noise(0, 1);
        clear_stats();
        cyc(1, 0, 2'b01, 16'd0, 1'b0);
        repeat (10) cyc_noise(0, 0);
        cyc(1, 1, 2'b11, 16'd0, 1'b0);
        check_val("stop_busy", busy, 0);
        check_val("stop_enb",  ramp_enb, 0);
        clear_stats();
        repeat (3) cyc_noise(0, 0);
        check_val("stop_quiet", n_delta, 0);
        $display("scenario stop_beats_start: level %0d busy %0d", level, busy);

        // Asynchronous reset mid-run
        clear_stats();
        cyc(1, 0, 2'b10, 16'd0, 1'b0);
        repeat (5) cyc_noise(0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        cyc_noise(0, 0);
        $display("scenario async_reset: level %0d busy %0d", level, busy);

        // Zero step: deltas forever, no completion
        clear_stats();
        cyc(1, 0, 2'b00, 16'd1, 1'b0);
        clear_stats();
        repeat (2000) cyc_noise(0, 0);
        check_val("zero_deltas", n_delta, 1000);
        check_val("zero_done",   n_done, 0);
        check_val("zero_wrap",   n_wrap, 0);
        check_val("zero_max",    max_level, 0);
        $display("scenario zero_step: deltas %0d", n_delta);
        cyc_noise(0, 1);

        // Random traffic
        for (int ep = 0; ep < 25; ep++) begin
            clear_stats();
            for (int c = 0; c < 160; c++) begin
                cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0),
                    2'($urandom_range(0, 3)), 16'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
            end
            $display("scenario random_%0d: deltas %0d done %0d wrap %0d", ep, n_delta, n_done, n_wrap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
